// File: rtl/irq_debouncer.sv
// irq_debouncer
//   Turns raw asynchronous interrupt request lines (buttons, switches) into
//   clean single-event pulses for the CP0 interrupt samplers. Each channel is
//   independently synchronised, debounced, rising-edge detected and stretched
//   into a PULSE_CYCLES-wide pulse. Bit N-1 is the highest CP0 priority.
//
// Parameters
//   N               number of channels
//   DEBOUNCE_CYCLES consecutive disagreeing samples needed to accept a change (>=1)
//   PULSE_CYCLES    width of each intsrc pulse in clocks (>=1)
//   INV_MASK        per-channel input inversion for active-low lines
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   raw_in     [N]   asynchronous request lines
//   intsrc     [N]   per-channel interrupt pulses (registered)
//   level      [N]   debounced stable level per channel
//   stats_clr        clears all event counters       (IRQ_DEBOUNCE_STATS_EN only)
//   evt_count  [8N]  saturating accepted-rise counts,
//                    channel i in bits [8i+7:8i]     (IRQ_DEBOUNCE_STATS_EN only)
//
// Build option
//   `define IRQ_DEBOUNCE_STATS_EN adds the event counters and their ports.

module irq_debouncer #(
  parameter int             N               = 3,
  parameter int             DEBOUNCE_CYCLES = 100000,
  parameter int             PULSE_CYCLES    = 1,
  parameter logic [N-1:0]   INV_MASK        = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   raw_in,
`ifdef IRQ_DEBOUNCE_STATS_EN
  input  logic           stats_clr,
  output logic [8*N-1:0] evt_count,
`endif
  output logic [N-1:0]   intsrc,
  output logic [N-1:0]   level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PC_LOAD  = PW'(PULSE_CYCLES - 1);

  typedef enum logic {IDLE, PULSE} pstate_t;

  logic [N-1:0] s1, s2;

  // Inversion happens before the synchroniser so every later stage sees
  // active-high requests; reset clears the chain, so idle-high inverted lines
  // come out of reset reading 0 and cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in ^ INV_MASK;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          stb, stb_d, rise;
    logic [CW-1:0] cnt;
    pstate_t       state, state_nxt;
    logic [PW-1:0] pc, pc_nxt;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; the D-th consecutive disagreeing sample flips the level.
    always_ff @(posedge clk) begin
      if (rst) begin
        stb   <= 1'b0;
        stb_d <= 1'b0;
        cnt   <= '0;
      end else begin
        stb_d <= stb;
        if (s2[i] == stb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stb <= ~stb;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign rise = stb & ~stb_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        pc    <= '0;
      end else begin
        state <= state_nxt;
        pc    <= pc_nxt;
      end
    end

    // A rise during PULSE reloads the down-counter, merging back-to-back
    // events into one longer pulse instead of a second separate one.
    always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = PULSE;
            pc_nxt    = PC_LOAD;
          end
        end
        PULSE: begin
          if (rise) begin
            pc_nxt = PC_LOAD;
          end else if (pc == '0) begin
            state_nxt = IDLE;
          end else begin
            pc_nxt = pc - 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    assign intsrc[i] = (state == PULSE);
    assign level[i]  = stb;

`ifdef IRQ_DEBOUNCE_STATS_EN
    logic [7:0] ec;

    // Clear wins over a same-cycle rise; the count sticks at 255.
    always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
        ec <= '0;
      end else if (rise && (ec != 8'hFF)) begin
        ec <= ec + 1'b1;
      end
    end

    assign evt_count[8*i +: 8] = ec;
`endif
  end

endmodule
